// File: rtl/fcvt_arbiter.sv
// Round-robin arbiter sharing one float->int32 converter among NREQ requesters.
// Optional FCVT_SAT_EN: saturate out-of-range/inf/NaN inputs instead of wrapping.
module fcvt_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_y,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic              busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_q;
    logic [31:0]   op_q;
    logic [CW-1:0] cnt_q;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic          ack;

    // Scan from the rr pointer upward, wrapping, and take the first valid.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    assign req_ready = (state_q == IDLE && gnt_any) ?
                       (NREQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state_q == DONE) ? (NREQ'(1) << gnt_q) : '0;
    assign busy      = (state_q != IDLE);
    assign ack       = (state_q == DONE) && rsp_ready[gnt_q];

    logic [7:0]  e;
    logic [7:0]  shamt;
    logic [32:0] mant;
    logic [32:0] mag2;
    logic [31:0] mag;
    logic [31:0] raw;
    logic [31:0] conv;

    // Mantissa left-justified in 32 bits: value*2 = mant >> (157-e).
    always_comb begin
        e     = op_q[30:23];
        shamt = 8'd157 - e;
        mant  = {2'b01, op_q[22:0], 8'h00};
        mag2  = (mant >> shamt) + 33'd1;
        mag   = mag2[32:1];
        raw   = op_q[31] ? (-mag) : mag;
`ifdef FCVT_SAT_EN
        if (e == 8'hFF && op_q[22:0] != 23'd0)
            conv = 32'h7FFF_FFFF;
        else if (e >= 8'd158)
            conv = op_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            conv = raw;
`else
        conv = raw;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            rsp_y   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q    <= req_x[gnt_idx*32 +: 32];
                        gnt_q   <= gnt_idx;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(LAT - 1)) begin
                        rsp_y   <= conv;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        ptr_q   <= (gnt_q == PW'(NREQ - 1)) ?
                                   '0 : gnt_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Directed self-checking bench for fcvt_arbiter (NREQ=2, LAT=1).
// Saturation vectors run only when FCVT_SAT_EN is defined.
module tb_fcvt_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [63:0] req_x;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_y;
    logic [1:0]  rsp_ready;
    logic        busy;

    int checks;
    int fails;

    fcvt_arbiter #(.NREQ(2), .LAT(1)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_y    (rsp_y),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: one full transaction on requester i, returns result and
    // cycles from the req_ready cycle to the first rsp_valid cycle.
    task automatic run_conv(input int i, input logic [31:0] x,
                            output logic [31:0] y, output int lat);
        int n;
        req_valid[i] = 1'b1;
        req_x[32*i +: 32] = x;
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin
            cyc();
            n++;
        end
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            y = 32'h0;
            lat = -1;
            return;
        end
        cyc();
        req_valid[i] = 1'b0;
        req_x[32*i +: 32] = 32'hDEAD_BEEF;
        lat = 1;
        while (!rsp_valid[i] && lat < 20) begin
            cyc();
            lat++;
        end
        if (!rsp_valid[i]) begin
            y = 32'h0;
            lat = -1;
            return;
        end
        y = rsp_y;
        rsp_ready[i] = 1'b1;
        cyc();
        rsp_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc();
        cyc();
        checks++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("FAIL reset_req_ready got=%b exp=00", req_ready);
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            fails++;
            $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid);
        end
        checks++;
        if (rsp_y !== 32'h0) begin
            fails++;
            $display("FAIL reset_rsp_y got=%h exp=00000000", rsp_y);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [31:0] y;
        int lat;
        run_conv(0, 32'h3FC0_0000, y, lat);
        checks++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL basic_latency got=%0d exp=2", lat);
        end
        checks++;
        if (y !== 32'h0000_0002) begin
            fails++;
            $display("FAIL basic_1p5 got=%h exp=00000002", y);
        end
    endtask

    task automatic test_values();
        logic [31:0] xs [6];
        logic [31:0] es [6];
        logic [31:0] y;
        int lat;
        xs = '{32'hBF80_0000, 32'h4020_0000, 32'h3E80_0000,
               32'h8000_0000, 32'h3F00_0000, 32'hC020_0000};
        es = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000,
               32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFD};
        for (int k = 0; k < 6; k++) begin
            run_conv(1, xs[k], y, lat);
            checks++;
            if (y !== es[k] || lat !== 2) begin
                fails++;
                $display("FAIL values x=%h got=%h lat=%0d exp=%h lat=2",
                         xs[k], y, lat, es[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        int ng;
        int n;
        logic [1:0] exp_g;
        req_x = {32'h4020_0000, 32'h3FC0_0000};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        exp_g = 2'b01;
        #1;
        ng = 0;
        n = 0;
        while (ng < 6 && n < 100) begin
            if (req_ready != 2'b00) begin
                checks++;
                if (req_ready !== exp_g) begin
                    fails++;
                    $display("FAIL rr_grant#%0d got=%b exp=%b",
                             ng, req_ready, exp_g);
                end
                exp_g = ~exp_g;
                ng++;
            end
            if (rsp_valid != 2'b00) begin
                checks++;
                if (rsp_y !== ((rsp_valid == 2'b01) ? 32'd2 : 32'd3)) begin
                    fails++;
                    $display("FAIL rr_result owner=%b got=%h",
                             rsp_valid, rsp_y);
                end
            end
            cyc();
            n++;
        end
        checks++;
        if (ng != 6) begin
            fails++;
            $display("FAIL rr_timeout got=%0d grants exp=6", ng);
        end
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        rsp_ready = 2'b00;
        cyc();
    endtask

    task automatic test_hold_done();
        int n;
        req_x = {32'h4020_0000, 32'h3FC0_0000};
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL hold_first_grant got=%b exp=01", req_ready);
        end
        cyc();
        req_valid[0] = 1'b0;
        req_x[31:0] = 32'h0;
        cyc();
        cyc();
        rsp_ready = 2'b10;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 2'b01 || rsp_y !== 32'd2 ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_stable c%0d v=%b y=%h rdy=%b busy=%b",
                         k, rsp_valid, rsp_y, req_ready, busy);
            end
            cyc();
        end
        rsp_ready = 2'b01;
        cyc();
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            fails++;
            $display("FAIL hold_after_ack v=%b rdy=%b exp v=00 rdy=10",
                     rsp_valid, req_ready);
        end
        cyc();
        req_valid = 2'b00;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (rsp_valid !== 2'b10 || rsp_y !== 32'd3) begin
            fails++;
            $display("FAIL hold_req1_result v=%b y=%h exp v=10 y=00000003",
                     rsp_valid, rsp_y);
        end
        rsp_ready = 2'b10;
        cyc();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [31:0] y;
        int lat;
        run_conv(0, 32'h3FC0_0000, y, lat);
        req_x = {32'h4020_0000, 32'h3FC0_0000};
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            fails++;
            $display("FAIL rstmid_grant1 got=%b exp=10", req_ready);
        end
        cyc();
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy_calc got=%b exp=1", busy);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 ||
            req_ready !== 2'b00 || rsp_y !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_async busy=%b v=%b rdy=%b y=%h",
                     busy, rsp_valid, req_ready, rsp_y);
        end
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        cyc();
        checks++;
        if (rsp_valid !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_no_stale got=%b exp=00", rsp_valid);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_ptr_cleared got=%b exp=01", req_ready);
        end
        req_valid = 2'b01;
        run_conv(0, 32'h3FC0_0000, y, lat);
        checks++;
        if (y !== 32'd2) begin
            fails++;
            $display("FAIL rstmid_result got=%h exp=00000002", y);
        end
    endtask

    task automatic test_sat();
        logic [31:0] y;
        int lat;
`ifdef FCVT_SAT_EN
        logic [31:0] xs [4];
        logic [31:0] es [4];
        xs = '{32'h4F32_D05E, 32'hFF80_0000, 32'h7FC0_0000, 32'h3FC0_0000};
        es = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};
        for (int k = 0; k < 4; k++) begin
            run_conv(1, xs[k], y, lat);
            checks++;
            if (y !== es[k] || lat !== 2) begin
                fails++;
                $display("FAIL sat x=%h got=%h lat=%0d exp=%h lat=2",
                         xs[k], y, lat, es[k]);
            end
        end
`else
        run_conv(1, 32'h3FC0_0000, y, lat);
        checks++;
        if (y !== 32'h0000_0002 || lat !== 2) begin
            fails++;
            $display("FAIL nosat_1p5 got=%h lat=%0d exp=00000002 lat=2",
                     y, lat);
        end
`endif
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rstn = 1'b0;
        req_valid = 2'b00;
        req_x = 64'h0;
        rsp_ready = 2'b00;
        test_reset();
        test_basic();
        test_values();
        test_round_robin();
        test_hold_done();
        test_reset_mid();
        test_sat();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
